evm_stack: RTL

EVM_STACK -- requirements
Module: evm_stack

---
 rtl/eesic_pkg.sv | 20 ++
 rtl/stack_ram.sv | 32 +++
 rtl/evm_stack.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/eesic_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : eesic_pkg
// Purpose : Shared widths, window size and controller state encoding.
// Rev     : 1.0
//------------------------------------------------------------------------------
package eesic_pkg;
    localparam int WORD_W    = 256;
    localparam int WIN       = 17;
    localparam int DEPTH_DEF = 1024;
    localparam int HEIGHT_W  = $clog2(DEPTH_DEF + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SPILL = 2'd1,
        FILL  = 2'd2,
        FAULT = 2'd3
    } state_t;
endpackage
`default_nettype wire

// File: rtl/stack_ram.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : stack_ram
// Purpose : Single-port synchronous-read storage for entries below the window.
// Rev     : 1.0
//------------------------------------------------------------------------------
module stack_ram
    import eesic_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);
    logic [WORD_W-1:0] r_mem [0:DEPTH-1];
    logic [WORD_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) r_mem[addr] <= wdata;
            else    r_rdata     <= r_mem[addr];
        end
    end

    assign rdata = r_rdata;
endmodule
`default_nettype wire

// File: rtl/evm_stack.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : evm_stack
// Purpose : EVM operand stack; register window on top, RAM spill/fill below.
// Rev     : 1.0
//------------------------------------------------------------------------------
module evm_stack
    import eesic_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int WIN   = eesic_pkg::WIN
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmt_valid,
    output logic                cmt_ready,
    input  logic [4:0]          push_num,
    input  logic [4:0]          pop_num,
    input  logic [WORD_W-1:0]   data_in    [0:WIN-1],
    output logic [WORD_W-1:0]   stack_data [0:WIN-1],
    output logic [HEIGHT_W-1:0] stack_height,
    output logic                fault
);
    localparam int AW  = $clog2(DEPTH);
    localparam int HW1 = HEIGHT_W + 1;
    localparam logic [HW1-1:0] c_depth = HW1'(DEPTH);
    localparam logic [4:0]     c_win   = 5'(WIN);

    state_t                r_state;
    logic [HEIGHT_W-1:0]   r_height;
    logic                  r_fault;
    logic [WORD_W-1:0]     r_win [0:WIN-1];
    logic [WORD_W-1:0]     r_buf [0:WIN-1];
    logic [4:0]            r_idx;
    logic [4:0]            r_wb_idx;
    logic [4:0]            r_cnt;
    logic [AW-1:0]         r_addr;
    logic                  r_rd_valid;

    logic                  w_accept;
    logic                  w_err;
    logic [HW1-1:0]        w_sum;
    logic [HW1-1:0]        w_new_h;
    logic [4:0]            w_d;
    logic [4:0]            w_lo;
    logic [4:0]            w_old_top;
    logic [4:0]            w_new_top;
    logic [4:0]            w_spill_cnt;
    logic [4:0]            w_fill_cnt;
    logic [5:0]            w_src      [0:WIN-1];
    logic [WORD_W-1:0]     w_next_win [0:WIN-1];
    logic                  w_ram_en;
    logic [WORD_W-1:0]     w_ram_rdata;

    assign w_accept = cmt_valid && (r_state == IDLE);
    assign w_sum    = HW1'(r_height) + HW1'(push_num);
    assign w_new_h  = w_sum - HW1'(pop_num);
    assign w_err    = (push_num > c_win) || (pop_num > c_win) ||
                      (HW1'(pop_num) > HW1'(r_height)) || (w_new_h > c_depth);

    // Slots [w_lo, WIN-1] are the ones leaving (grow) or entering (shrink) the window.
    assign w_d         = (push_num >= pop_num) ? push_num - pop_num : pop_num - push_num;
    assign w_lo        = c_win - w_d;
    assign w_old_top   = (r_height >= HEIGHT_W'(WIN)) ? c_win : r_height[4:0];
    assign w_new_top   = (w_new_h >= HW1'(WIN)) ? c_win : w_new_h[4:0];
    assign w_spill_cnt = ((push_num > pop_num) && (w_old_top > w_lo)) ? w_old_top - w_lo : 5'd0;
    assign w_fill_cnt  = ((pop_num > push_num) && (w_new_top > w_lo)) ? w_new_top - w_lo : 5'd0;

    always_comb begin
        for (int i = 0; i < WIN; i++) begin
            w_src[i]      = 6'(i) - 6'(push_num) + 6'(pop_num);
            w_next_win[i] = '0;
            if (5'(i) < push_num)
                w_next_win[i] = data_in[i];
            else if (w_src[i] < 6'(WIN))
                w_next_win[i] = r_win[w_src[i][4:0]];
            if (HW1'(i) >= w_new_h)
                w_next_win[i] = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_height   <= '0;
            r_fault    <= 1'b0;
            r_idx      <= '0;
            r_wb_idx   <= '0;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_rd_valid <= 1'b0;
            for (int i = 0; i < WIN; i++) r_win[i] <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_err) begin
                            r_state <= FAULT;
                            r_fault <= 1'b1;
                        end else begin
                            r_win    <= w_next_win;
                            r_height <= HEIGHT_W'(w_new_h);
                            if (w_spill_cnt != 5'd0) begin
                                r_state <= SPILL;
                                r_cnt   <= w_spill_cnt;
                                r_idx   <= w_old_top - 5'd1;
                                r_addr  <= AW'(r_height - HEIGHT_W'(w_old_top));
                            end else if (w_fill_cnt != 5'd0) begin
                                r_state    <= FILL;
                                r_cnt      <= w_fill_cnt;
                                r_idx      <= w_lo;
                                r_addr     <= AW'(w_new_h - HW1'(w_lo) - HW1'(1));
                                r_rd_valid <= 1'b0;
                            end
                        end
                    end
                end
                SPILL: begin
                    r_idx  <= r_idx - 5'd1;
                    r_addr <= r_addr + 1'b1;
                    r_cnt  <= r_cnt - 5'd1;
                    if (r_cnt == 5'd1) r_state <= IDLE;
                end
                FILL: begin
                    if (r_cnt != 5'd0) begin
                        r_wb_idx   <= r_idx;
                        r_idx      <= r_idx + 5'd1;
                        r_addr     <= r_addr - 1'b1;
                        r_cnt      <= r_cnt - 5'd1;
                        r_rd_valid <= 1'b1;
                    end else begin
                        r_rd_valid <= 1'b0;
                    end
                    if (r_rd_valid) begin
                        r_win[r_wb_idx] <= w_ram_rdata;
                        if (r_cnt == 5'd0) r_state <= IDLE;
                    end
                end
                default: r_state <= FAULT;
            endcase
        end
    end

    // Snapshot of the pre-commit window; spills drain from it after the shift.
    always_ff @(posedge clk) begin
        if (w_accept) r_buf <= r_win;
    end

    assign w_ram_en = (r_state == SPILL) || ((r_state == FILL) && (r_cnt != 5'd0));

    stack_ram #(.DEPTH(DEPTH)) u_ram (
        .clk   (clk),
        .en    (w_ram_en),
        .we    (r_state == SPILL),
        .addr  (r_addr),
        .wdata (r_buf[r_idx]),
        .rdata (w_ram_rdata)
    );

    assign stack_data   = r_win;
    assign stack_height = r_height;
    assign cmt_ready    = (r_state == IDLE);
    assign fault        = r_fault;
endmodule
`default_nettype wire
